sram_b_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a 1w:1r banked SRAM with 17-bit addresses and 8-bit words, such as the unisim-mapped sram_b macros. Two clients issue read or write requests over valid/ready. The block grants the write port (CE0/A0/D0/WE0/WEM0) and the read port (CE1/A1) independently with per-port round-robin. It prevents same-address read/write collisions and returns read data in order through a per-requester 2-entry response FIFO with credit-based backpressure.

---
 rtl/sram_b_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_b_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_b_port_arbiter.sv
// sram_b_port_arbiter: two-client arbiter/sequencer for a 1w:1r sram_b macro.
// The write port and the read port are each granted independently with their
// own round-robin pointer. A read that hits the address being written in the
// same cycle is held off so it observes the new data. Read data returns through
// a 2-entry FIFO per client, and credit-based flow control keeps that FIFO from
// overflowing.
// Optional build macro SRAM_B_ARB_STATS_EN adds the STAT_CONFLICT counter output.
module sram_b_port_arbiter #(
    parameter int ABITS = 17,
    parameter int DBITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic             REQ0_WE,
    input  logic [ABITS-1:0] REQ0_A,
    input  logic [DBITS-1:0] REQ0_D,
    input  logic [DBITS-1:0] REQ0_WEM,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic             REQ1_WE,
    input  logic [ABITS-1:0] REQ1_A,
    input  logic [DBITS-1:0] REQ1_D,
    input  logic [DBITS-1:0] REQ1_WEM,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic [DBITS-1:0] RSP0_Q,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [DBITS-1:0] RSP1_Q,
`ifdef SRAM_B_ARB_STATS_EN
    output logic [15:0]      STAT_CONFLICT,
`endif
    output logic             CE0,
    output logic             WE0,
    output logic [ABITS-1:0] A0,
    output logic [DBITS-1:0] D0,
    output logic [DBITS-1:0] WEM0,
    output logic             CE1,
    output logic [ABITS-1:0] A1,
    input  logic [DBITS-1:0] Q1
);

    // Per-client views of the request ports so both clients share one code path.
    logic [1:0]       vld, we, rrdy;
    logic [ABITS-1:0] a   [2];
    logic [DBITS-1:0] d   [2];
    logic [DBITS-1:0] wem [2];

    assign vld  = {REQ1_VALID, REQ0_VALID};
    assign we   = {REQ1_WE, REQ0_WE};
    assign rrdy = {RSP1_READY, RSP0_READY};
    assign a[0] = REQ0_A;   assign a[1] = REQ1_A;
    assign d[0] = REQ0_D;   assign d[1] = REQ1_D;
    assign wem[0] = REQ0_WEM; assign wem[1] = REQ1_WEM;

    logic             wr_prio, rd_prio;
    logic [1:0]       inflight;
    logic [1:0]       cnt  [2];
    logic [1:0]       rptr, wptr;
    logic [DBITS-1:0] fq   [2][2];

    logic [1:0]       wr_cand, wr_gnt, rd_base, rd_cand, rd_gnt, coll, credit, pop;
    logic [ABITS-1:0] wa;

    // Grant logic: write arbitration first, because its address gates reads.
    always_comb begin
        pop    = '0;
        credit = '0;
        coll   = '0;
        for (int i = 0; i < 2; i++) begin
            pop[i]    = (cnt[i] != 2'd0) & rrdy[i];
            // Slots committed (buffered + returning) after this cycle's pop.
            credit[i] = ({1'b0, cnt[i]} + {2'b0, inflight[i]} - {2'b0, pop[i]}) < 3'd2;
        end
        wr_cand   = vld & we & {2{~RST}};
        wr_gnt[0] = wr_cand[0] & (~wr_cand[1] | ~wr_prio);
        wr_gnt[1] = wr_cand[1] & (~wr_cand[0] |  wr_prio);
        wa        = wr_gnt[1] ? a[1] : a[0];
        rd_base   = vld & ~we & credit & {2{~RST}};
        for (int i = 0; i < 2; i++)
            coll[i] = rd_base[i] & (|wr_gnt) & (a[i] == wa);
        rd_cand   = rd_base & ~coll;
        rd_gnt[0] = rd_cand[0] & (~rd_cand[1] | ~rd_prio);
        rd_gnt[1] = rd_cand[1] & (~rd_cand[0] |  rd_prio);
    end

    assign REQ0_READY = wr_gnt[0] | rd_gnt[0];
    assign REQ1_READY = wr_gnt[1] | rd_gnt[1];

    // Memory ports follow the grants directly; an idle port drives all zeros.
    always_comb begin
        CE0  = |wr_gnt;
        WE0  = |wr_gnt;
        A0   = '0;
        D0   = '0;
        WEM0 = '0;
        CE1  = |rd_gnt;
        A1   = '0;
        if (|wr_gnt) begin
            A0   = wa;
            D0   = wr_gnt[1] ? d[1]   : d[0];
            WEM0 = wr_gnt[1] ? wem[1] : wem[0];
        end
        if (|rd_gnt)
            A1 = rd_gnt[1] ? a[1] : a[0];
    end

    assign RSP0_VALID = cnt[0] != 2'd0;
    assign RSP1_VALID = cnt[1] != 2'd0;
    assign RSP0_Q     = RSP0_VALID ? fq[0][rptr[0]] : '0;
    assign RSP1_Q     = RSP1_VALID ? fq[1][rptr[1]] : '0;

    // Priority pointers, inflight tracking and response FIFOs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_prio  <= 1'b0;
            rd_prio  <= 1'b0;
            inflight <= '0;
            rptr     <= '0;
            wptr     <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            if (|wr_gnt) wr_prio <= wr_gnt[0];
            if (|rd_gnt) rd_prio <= rd_gnt[0];
            inflight <= rd_gnt;
            for (int i = 0; i < 2; i++) begin
                if (inflight[i]) begin
                    fq[i][wptr[i]] <= Q1;
                    wptr[i]        <= ~wptr[i];
                end
                if (pop[i]) rptr[i] <= ~rptr[i];
                cnt[i] <= cnt[i] + {1'b0, inflight[i]} - {1'b0, pop[i]};
            end
        end
    end

`ifdef SRAM_B_ARB_STATS_EN
    // Saturating count of cycles where a read lost only to a same-address write.
    always_ff @(posedge CLK) begin
        if (RST)
            STAT_CONFLICT <= '0;
        else if ((|coll) && (STAT_CONFLICT != 16'hFFFF))
            STAT_CONFLICT <= STAT_CONFLICT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Bench for sram_b_port_arbiter: SRAM macro model plus reference memory and
// per-client response scoreboards.
module tb_sram_b_port_arbiter;
    localparam int ABITS = 17;
    localparam int DBITS = 8;

    logic CLK = 1'b0, RST = 1'b1;
    logic REQ0_VALID = 0, REQ0_WE = 0, REQ1_VALID = 0, REQ1_WE = 0;
    logic [ABITS-1:0] REQ0_A = '0, REQ1_A = '0;
    logic [DBITS-1:0] REQ0_D = '0, REQ0_WEM = '0, REQ1_D = '0, REQ1_WEM = '0;
    logic REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
    logic RSP0_READY = 1, RSP1_READY = 1;
    logic [DBITS-1:0] RSP0_Q, RSP1_Q, D0, WEM0, Q1 = '0;
    logic CE0, WE0, CE1;
    logic [ABITS-1:0] A0, A1;
`ifdef SRAM_B_ARB_STATS_EN
    logic [15:0] STAT_CONFLICT;
`endif

    sram_b_port_arbiter #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
        .REQ0_A(REQ0_A), .REQ0_D(REQ0_D), .REQ0_WEM(REQ0_WEM),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
        .REQ1_A(REQ1_A), .REQ1_D(REQ1_D), .REQ1_WEM(REQ1_WEM),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_Q(RSP0_Q),
        .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_Q(RSP1_Q),
`ifdef SRAM_B_ARB_STATS_EN
        .STAT_CONFLICT(STAT_CONFLICT),
`endif
        .CE0(CE0), .WE0(WE0), .A0(A0), .D0(D0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    // SRAM macro model: masked write, registered read.
    bit [DBITS-1:0] mem  [0:(1<<ABITS)-1];
    bit [DBITS-1:0] rmem [0:(1<<ABITS)-1];
    always @(posedge CLK) begin
        if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= mem[A1];
    end

    int n_chk = 0, n_fail = 0;
    int rsp_n0 = 0, rsp_n1 = 0;
    logic acc0, acc1;
    logic [DBITS-1:0] q0[$], q1[$];

    // Sample just before the edge: log acceptances into the reference model,
    // queue expected read data, and check any response being consumed.
    task automatic samp();
        logic [DBITS-1:0] e;
        @(negedge CLK);
        acc0 = !RST && REQ0_VALID && REQ0_READY === 1'b1;
        acc1 = !RST && REQ1_VALID && REQ1_READY === 1'b1;
        if (RST) begin q0.delete(); q1.delete(); end
        if (acc0 && REQ0_WE) rmem[REQ0_A] = (rmem[REQ0_A] & ~REQ0_WEM) | (REQ0_D & REQ0_WEM);
        if (acc1 && REQ1_WE) rmem[REQ1_A] = (rmem[REQ1_A] & ~REQ1_WEM) | (REQ1_D & REQ1_WEM);
        if (acc0 && !REQ0_WE) q0.push_back(rmem[REQ0_A]);
        if (acc1 && !REQ1_WE) q1.push_back(rmem[REQ1_A]);
        if (RSP0_VALID === 1'b1 && RSP0_READY) begin
            n_chk++; rsp_n0++;
            if (q0.size() == 0) begin
                n_fail++; $display("FAIL rsp0_scoreboard: got %h, no response expected", RSP0_Q);
            end else begin
                e = q0.pop_front();
                if (RSP0_Q !== e) begin n_fail++; $display("FAIL rsp0_scoreboard: got %h expected %h", RSP0_Q, e); end
            end
        end
        if (RSP1_VALID === 1'b1 && RSP1_READY) begin
            n_chk++; rsp_n1++;
            if (q1.size() == 0) begin
                n_fail++; $display("FAIL rsp1_scoreboard: got %h, no response expected", RSP1_Q);
            end else begin
                e = q1.pop_front();
                if (RSP1_Q !== e) begin n_fail++; $display("FAIL rsp1_scoreboard: got %h expected %h", RSP1_Q, e); end
            end
        end
    endtask

    task automatic adv(); @(posedge CLK); #1; endtask
    task automatic tick(); samp(); adv(); endtask
    task automatic idle(); REQ0_VALID = 0; REQ1_VALID = 0; endtask

    task automatic req(input int i, input logic w, input logic [ABITS-1:0] ad,
                       input logic [DBITS-1:0] dd, input logic [DBITS-1:0] mm);
        if (i == 0) begin REQ0_VALID = 1; REQ0_WE = w; REQ0_A = ad; REQ0_D = dd; REQ0_WEM = mm; end
        else        begin REQ1_VALID = 1; REQ1_WE = w; REQ1_A = ad; REQ1_D = dd; REQ1_WEM = mm; end
    endtask

    task automatic do_reset();
        idle(); RST = 1; adv(); adv(); RST = 0;
    endtask

    task automatic test_reset();
        req(0, 0, 17'h5, 0, 0); req(1, 1, 17'h6, 8'h11, 8'hFF);
        adv(); adv(); samp();
        n_chk++;
        if ({REQ0_READY, REQ1_READY} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {REQ0_READY, REQ1_READY}); end
        n_chk++;
        if ({CE0, WE0, CE1, A0, A1, D0, WEM0} !== '0) begin n_fail++; $display("FAIL reset_memport: got ce0=%b we0=%b ce1=%b a0=%h a1=%h expected zeros", CE0, WE0, CE1, A0, A1); end
        n_chk++;
        if ({RSP0_VALID, RSP1_VALID, RSP0_Q, RSP1_Q} !== '0) begin n_fail++; $display("FAIL reset_rsp: got v=%b%b expected 00 with Q=0", RSP0_VALID, RSP1_VALID); end
`ifdef SRAM_B_ARB_STATS_EN
        n_chk++;
        if (STAT_CONFLICT !== 16'd0) begin n_fail++; $display("FAIL reset_stat: got %0d expected 0", STAT_CONFLICT); end
`endif
        adv(); idle(); RST = 0; adv();
    endtask

    task automatic test_write_read();
        req(0, 1, 17'h1ABCD, 8'hA5, 8'hFF); samp();
        n_chk++;
        if ({REQ0_READY, CE0, WE0, A0, D0, WEM0} !== {3'b111, 17'h1ABCD, 8'hA5, 8'hFF}) begin
            n_fail++; $display("FAIL wr_port: got rdy=%b ce0=%b a0=%h d0=%h wem0=%h expected 1/1/1abcd/a5/ff", REQ0_READY, CE0, A0, D0, WEM0); end
        adv();
        req(0, 0, 17'h1ABCD, 0, 0); samp();
        n_chk++;
        if ({REQ0_READY, CE1, A1, CE0} !== {2'b11, 17'h1ABCD, 1'b0}) begin
            n_fail++; $display("FAIL rd_port: got rdy=%b ce1=%b a1=%h ce0=%b expected 1/1/1abcd/0", REQ0_READY, CE1, A1, CE0); end
        adv(); idle(); samp();
        n_chk++;
        if (RSP0_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_latency_early: got valid=%b expected 0", RSP0_VALID); end
        adv(); samp();
        n_chk++;
        if ({RSP0_VALID, RSP0_Q} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL rd_latency2: got valid=%b q=%h expected 1/a5", RSP0_VALID, RSP0_Q); end
        adv();
    endtask

    task automatic test_masked();
        bit seen = 0;
        req(0, 1, 17'h00200, 8'hFF, 8'hFF); tick();
        req(0, 1, 17'h00200, 8'h00, 8'h0F); tick();
        req(0, 0, 17'h00200, 0, 0); tick(); idle();
        for (int k = 0; k < 6 && !seen; k++) begin
            samp();
            if (RSP0_VALID === 1'b1) begin
                seen = 1; n_chk++;
                if (RSP0_Q !== 8'hF0) begin n_fail++; $display("FAIL masked_write: got %h expected f0", RSP0_Q); end
            end
            adv();
        end
        if (!seen) begin n_chk++; n_fail++; $display("FAIL masked_write: got no response expected f0"); end
    endtask

    task automatic test_contention();
        int b0, b1;
        req(0, 1, 17'h400, 8'h11, 8'hFF); tick();
        req(0, 1, 17'h401, 8'h22, 8'hFF); tick();
        do_reset();
        b0 = rsp_n0; b1 = rsp_n1;
        RSP0_READY = 1; RSP1_READY = 1;
        req(0, 0, 17'h400, 0, 0); req(1, 0, 17'h401, 0, 0);
        for (int k = 0; k < 8; k++) begin
            samp(); n_chk++;
            if ({REQ1_READY, REQ0_READY} !== ((k % 2) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", k, {REQ1_READY, REQ0_READY}, (k % 2) ? 2'b10 : 2'b01); end
            adv();
        end
        idle(); repeat (4) tick();
        n_chk++;
        if (rsp_n0 - b0 != 4 || rsp_n1 - b1 != 4 || q0.size() != 0 || q1.size() != 0) begin
            n_fail++; $display("FAIL contention_rsp: got %0d/%0d responses expected 4/4", rsp_n0 - b0, rsp_n1 - b1); end
    endtask

    task automatic test_collision();
        bit seen = 0;
`ifdef SRAM_B_ARB_STATS_EN
        logic [15:0] s0;
        s0 = STAT_CONFLICT;
`endif
        req(0, 1, 17'h00010, 8'h3C, 8'hFF); req(1, 0, 17'h00010, 0, 0); samp();
        n_chk++;
        if ({REQ0_READY, REQ1_READY, CE0, A0, CE1} !== {3'b101, 17'h00010, 1'b0}) begin
            n_fail++; $display("FAIL collision_block: got rdy0=%b rdy1=%b ce0=%b a0=%h ce1=%b expected 1/0/1/10/0", REQ0_READY, REQ1_READY, CE0, A0, CE1); end
        adv(); REQ0_VALID = 0; samp();
        n_chk++;
        if ({REQ1_READY, CE1, A1} !== {2'b11, 17'h00010}) begin
            n_fail++; $display("FAIL collision_retry: got rdy1=%b ce1=%b a1=%h expected 1/1/10", REQ1_READY, CE1, A1); end
        adv(); idle();
`ifdef SRAM_B_ARB_STATS_EN
        n_chk++;
        if (STAT_CONFLICT !== s0 + 16'd1) begin n_fail++; $display("FAIL stat_conflict: got %0d expected %0d", STAT_CONFLICT, s0 + 16'd1); end
`endif
        for (int k = 0; k < 5 && !seen; k++) begin
            samp();
            if (RSP1_VALID === 1'b1) begin
                seen = 1; n_chk++;
                if (RSP1_Q !== 8'h3C) begin n_fail++; $display("FAIL collision_data: got %h expected 3c", RSP1_Q); end
            end
            adv();
        end
        if (!seen) begin n_chk++; n_fail++; $display("FAIL collision_data: got no response expected 3c"); end
    endtask

    task automatic test_backpressure();
        int n = 0, m = 0;
        for (int k = 0; k < 4; k++) begin req(0, 1, 17'h300 + k, 8'hA0 + 8'(k), 8'hFF); tick(); end
        RSP0_READY = 0;
        req(0, 0, 17'h300, 0, 0);
        for (int k = 0; k < 6; k++) begin
            samp(); if (acc0) n++; adv(); if (acc0) REQ0_A = REQ0_A + 1;
        end
        n_chk++;
        if (n != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", n); end
        samp(); n_chk++;
        if ({REQ0_READY, RSP0_VALID, RSP0_Q} !== {2'b01, 8'hA0}) begin
            n_fail++; $display("FAIL bp_stall: got rdy=%b valid=%b q=%h expected 0/1/a0", REQ0_READY, RSP0_VALID, RSP0_Q); end
        adv();
        RSP0_READY = 1;
        for (int k = 0; k < 6; k++) begin
            samp(); if (acc0) m++; adv(); if (acc0) REQ0_A = REQ0_A + 1;
        end
        idle(); repeat (4) tick();
        n_chk++;
        if (m == 0 || q0.size() != 0) begin n_fail++; $display("FAIL bp_resume: got %0d new accepts, %0d pending expected >0 and 0", m, q0.size()); end
    endtask

    task automatic test_reset_mid();
        RSP0_READY = 1;
        req(0, 0, 17'h400, 0, 0); samp();
        n_chk++;
        if (REQ0_READY !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 1", REQ0_READY); end
        adv(); idle(); RST = 1; samp();
        n_chk++;
        if ({REQ0_READY, REQ1_READY, CE0, CE1} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_outputs: got %b expected 0000", {REQ0_READY, REQ1_READY, CE0, CE1}); end
        adv(); RST = 0;
        for (int k = 0; k < 4; k++) begin
            samp(); n_chk++;
            if ({RSP0_VALID, RSP1_VALID, RSP0_Q, RSP1_Q, CE0, WE0, CE1, A0, A1, D0, WEM0} !== '0) begin
                n_fail++; $display("FAIL rstmid_quiet%0d: got rsp_v=%b%b ce0=%b ce1=%b expected all 0", k, RSP0_VALID, RSP1_VALID, CE0, CE1); end
            adv();
        end
        req(0, 0, 17'h400, 0, 0); req(1, 0, 17'h401, 0, 0); samp();
        n_chk++;
        if ({REQ1_READY, REQ0_READY} !== 2'b01) begin n_fail++; $display("FAIL rstmid_rdprio: got %b expected 01", {REQ1_READY, REQ0_READY}); end
        adv(); idle(); repeat (3) tick();
        req(0, 1, 17'h500, 8'h01, 8'hFF); req(1, 1, 17'h501, 8'h02, 8'hFF); samp();
        n_chk++;
        if ({REQ1_READY, REQ0_READY} !== 2'b01) begin n_fail++; $display("FAIL rstmid_wrprio: got %b expected 01", {REQ1_READY, REQ0_READY}); end
        adv(); idle(); repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked();
        test_contention();
        test_collision();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
